// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: a shared free-running divider drives per-channel
// off/on/blink/breathe patterns, edited through four debounced push-button levels.
module led_pattern_ctrl #(
  parameter int unsigned CH      = 4,
  parameter int unsigned DIV_W   = 29,
  parameter int unsigned SEL_RST = 23,
  localparam int unsigned CW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_btn_fast,
  input  logic          i_btn_slow,
  input  logic          i_btn_mode,
  input  logic          i_btn_ch,
  output logic [CH-1:0] o_led,
  output logic [CW-1:0] o_ch_sel,
  output logic [4:0]    o_cur_sel,
  output logic [1:0]    o_cur_mode
);

  typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModeBreathe} mode_e;

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_prev;
  logic [4:0]       r_sel [CH];
  mode_e            r_mode [CH];
  logic [CW-1:0]    r_ch_sel;
  logic [CH-1:0]    r_led;

  logic [3:0]       w_btn;
  logic [3:0]       w_press;
  logic [31:0]      w_div_x;
  logic [CH-1:0]    w_led_next;
  logic             w_fast;
  logic             w_slow;

  // Button order in the vectors: {ch, mode, slow, fast}.
  assign w_btn   = {i_btn_ch, i_btn_mode, i_btn_slow, i_btn_fast};
  assign w_press = w_btn & ~r_prev;
  assign w_div_x = 32'(r_div);

  // Opposing speed presses in the same cycle cancel out.
  assign w_fast = w_press[0] & ~w_press[1];
  assign w_slow = w_press[1] & ~w_press[0];

  function automatic logic pattern_bit(input mode_e mode, input logic [4:0] sel,
                                       input logic [31:0] div);
    logic [4:0] e;
    logic [7:0] frac;
    logic [7:0] ramp;
    logic       res;
    e    = (sel < 5'd8) ? 5'd8 : sel;
    frac = 8'(div >> (e - 5'd8));
    // Triangle ramp: rising while div[e] is low, falling while it is high.
    ramp = div[e] ? ~frac : frac;
    unique case (mode)
      ModeOff:   res = 1'b0;
      ModeOn:    res = 1'b1;
      ModeBlink: res = div[sel];
      default:   res = (div[7:0] < ramp);
    endcase
    return res;
  endfunction

  always_comb begin
    w_led_next = '0;
    for (int i = 0; i < CH; i++) begin
      w_led_next[i] = pattern_bit(r_mode[i], r_sel[i], w_div_x);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div    <= '0;
      r_prev   <= '0;
      r_ch_sel <= '0;
      r_led    <= '0;
      for (int i = 0; i < CH; i++) begin
        r_sel[i]  <= 5'(SEL_RST);
        r_mode[i] <= ModeBlink;
      end
    end else begin
      r_div  <= r_div + DIV_W'(1);
      r_prev <= w_btn;
      r_led  <= w_led_next;
      // Edits target the channel selected before any channel press in this cycle.
      if (w_press[2]) begin
        r_mode[r_ch_sel] <= mode_e'(r_mode[r_ch_sel] + 2'd1);
      end
      if (w_fast && (r_sel[r_ch_sel] != 5'd0)) begin
        r_sel[r_ch_sel] <= r_sel[r_ch_sel] - 5'd1;
      end else if (w_slow && (r_sel[r_ch_sel] != 5'(DIV_W - 1))) begin
        r_sel[r_ch_sel] <= r_sel[r_ch_sel] + 5'd1;
      end
      if (w_press[3]) begin
        r_ch_sel <= (r_ch_sel == CW'(CH - 1)) ? '0 : r_ch_sel + CW'(1);
      end
    end
  end

  assign o_led      = r_led;
  assign o_ch_sel   = r_ch_sel;
  assign o_cur_sel  = r_sel[r_ch_sel];
  assign o_cur_mode = r_mode[r_ch_sel];

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: arithmetic reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_led_pattern_ctrl;

  localparam int CH      = 4;
  localparam int DIV_W   = 12;
  localparam int SEL_RST = 9;

  logic       clk;
  logic       rst;
  logic [3:0] btn;  // {ch, mode, slow, fast}
  logic [3:0] led;
  logic [1:0] ch_sel;
  logic [4:0] cur_sel;
  logic [1:0] cur_mode;

  led_pattern_ctrl #(
    .CH     (CH),
    .DIV_W  (DIV_W),
    .SEL_RST(SEL_RST)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn_fast(btn[0]),
    .i_btn_slow(btn[1]),
    .i_btn_mode(btn[2]),
    .i_btn_ch  (btn[3]),
    .o_led     (led),
    .o_ch_sel  (ch_sel),
    .o_cur_sel (cur_sel),
    .o_cur_mode(cur_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  int         m_div;
  int         m_ch;
  int         m_sel [CH];
  int         m_mode [CH];
  logic [3:0] m_prev;
  logic [3:0] m_led;
  logic [3:0] p;

  assign p = btn & ~m_prev;

  function automatic logic led_of(input int mode, input int sel, input int div);
    int e, frac, ramp;
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 2) return ((div >> sel) % 2) == 1;
    e    = (sel < 8) ? 8 : sel;
    frac = (div >> (e - 8)) % 256;
    ramp = ((div >> e) % 2 == 1) ? 255 - frac : frac;
    return (div % 256) < ramp;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div  <= 0;
      m_ch   <= 0;
      m_prev <= '0;
      m_led  <= '0;
      for (int i = 0; i < CH; i++) begin
        m_sel[i]  <= SEL_RST;
        m_mode[i] <= 2;
      end
    end else begin
      m_div  <= (m_div + 1) % (1 << DIV_W);
      m_prev <= btn;
      for (int i = 0; i < CH; i++) m_led[i] <= led_of(m_mode[i], m_sel[i], m_div);
      if (p[2]) m_mode[m_ch] <= (m_mode[m_ch] + 1) % 4;
      if (p[0] && !p[1]) m_sel[m_ch] <= (m_sel[m_ch] > 0) ? m_sel[m_ch] - 1 : 0;
      if (p[1] && !p[0]) m_sel[m_ch] <= (m_sel[m_ch] < DIV_W - 1) ? m_sel[m_ch] + 1 : m_sel[m_ch];
      if (p[3]) m_ch <= (m_ch + 1) % CH;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_led", led, m_led);
      chk("model_ch_sel", ch_sel, m_ch);
      chk("model_cur_sel", cur_sel, m_sel[m_ch]);
      chk("model_cur_mode", cur_mode, m_mode[m_ch]);
    end
  end

  // Drive a button mask for one cycle, then release for one cycle.
  task automatic press(input logic [3:0] mask);
    btn = mask;
    @(posedge clk); #1;
    btn = '0;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int bad;
    logic a;
    int duty [4];
    rst = 1'b0;
    btn = '0;
    #2 rst = 1'b1;
    #1;
    cmp_en = 1'b1;
    chk("rst_led", led, 0);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_cur_sel", cur_sel, 9);
    chk("rst_cur_mode", cur_mode, 2);
    #19 rst = 1'b0;

    // Blink at sel=9: first rise on edge 513 after release, then 512-cycle half period
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (led[0] !== 1'b1 && n < 2000);
    chk("blink_first_rise", n, 513);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (led[0] !== 1'b0 && n < 2000);
    chk("blink_half_period", n, 512);

    // Speed saturation at 0
    for (int i = 1; i <= 12; i++) begin
      press(4'b0001);
      chk("fast_sat", cur_sel, (9 - i > 0) ? 9 - i : 0);
    end
    @(posedge clk); #1; a = led[0];
    @(posedge clk); #1;
    chk("sel0_toggle", led[0] ^ a, 1);
    for (int i = 1; i <= 15; i++) begin
      press(4'b0010);
      chk("slow_sat", cur_sel, (i < 11) ? i : 11);
    end
    press(4'b0001);
    press(4'b0001);
    chk("ch0_back", cur_sel, 9);

    // Channel wrap and isolation
    for (int i = 1; i <= 4; i++) begin
      press(4'b1000);
      chk("ch_wrap", ch_sel, i % 4);
    end
    press(4'b1000);
    press(4'b1000);
    press(4'b0010);
    chk("ch2_sel", cur_sel, 10);
    press(4'b1000); chk("ch3_sel", cur_sel, 9);
    press(4'b1000); chk("ch0_sel", cur_sel, 9);
    press(4'b1000); chk("ch1_sel", cur_sel, 9);

    // Simultaneous events
    press(4'b0011);
    chk("fast_slow_sel", cur_sel, 9);
    chk("fast_slow_ch", ch_sel, 1);
    press(4'b1100);
    chk("chmode_ch", ch_sel, 2);
    chk("chmode_ch2_mode", cur_mode, 2);
    press(4'b1000);
    press(4'b1000);
    press(4'b1000);
    chk("chmode_ch1_mode", cur_mode, 3);

    // Mode cycle on ch3
    press(4'b1000);
    press(4'b1000);
    chk("ch3_sel_now", ch_sel, 3);
    press(4'b0100);
    chk("ch3_breathe", cur_mode, 3);
    n = 0;
    while (m_div != 1 && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("breathe_align", m_div, 1);
    for (int w = 0; w < 4; w++) begin
      duty[w] = 0;
      for (int c = 0; c < 256; c++) begin
        if (led[3] === 1'b1) duty[w]++;
        @(negedge clk);
      end
    end
    chk("breathe_duty0", duty[0], 0);
    chk("breathe_duty1", duty[1], 255);
    chk("breathe_duty2", duty[2], 170);
    chk("breathe_duty3", duty[3], 85);
    #1;
    press(4'b0100);
    bad = 0;
    repeat (20) begin
      if (led[3] !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("off_const0", bad, 0);
    press(4'b0100);
    bad = 0;
    repeat (20) begin
      if (led[3] !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("on_const1", bad, 0);
    press(4'b0100);
    chk("back_blink", cur_mode, 2);

    // Held button: one increment only
    btn = 4'b0010;
    cycles(1000);
    btn = '0;
    cycles(1);
    chk("held_once", cur_sel, 10);

    // Held across reset: one press after release, on ch0
    btn = 4'b0010;
    cycles(1);
    chk("held2_first", cur_sel, 11);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_ch_sel", ch_sel, 0);
    chk("mid_rst_cur_sel", cur_sel, 9);
    chk("mid_rst_cur_mode", cur_mode, 2);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("held_rst_once", cur_sel, 10);
    cycles(50);
    chk("held_rst_stay", cur_sel, 10);
    btn = '0;
    cycles(3);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
